// File: rtl/mem_stage_access.sv
// mem_stage_access: Y86-64 memory-stage data access over a req/rsp memory port
module mem_stage_access #(
    parameter int unsigned MEM_BYTES = 65536,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [2:0]  M_stat_i,
    input  logic [3:0]  M_icode_i,
    input  logic [63:0] M_valE_i,
    input  logic [63:0] M_valA_i,
    input  logic        adv_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    input  logic        mem_ready_i,
    input  logic        mem_rvalid_i,
    input  logic [63:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic [63:0] m_valM_o,
    output logic [2:0]  m_stat_o,
    output logic        m_busy_o,
    output logic [31:0] m_stall_cnt_o
);
    localparam logic [2:0] SAOK    = 3'd1;
    localparam logic [2:0] SADR    = 3'd3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state_q;
    logic          req_q;
    logic          we_q;
    logic [63:0]   addr_q;
    logic [63:0]   wdata_q;
    logic [63:0]   valm_q;
    logic          err_q;
    logic [TW-1:0] cnt_q;
    logic [31:0]   stall_q;

    logic          is_rd;
    logic          is_wr;
    logic          is_mem;
    logic          in_range;
    logic [63:0]   addr_d;

    // Classify the M instruction and pick its address; range check is done
    // in 65 bits so addresses near 2^64 cannot wrap into range.
    always_comb begin
        is_rd    = (M_stat_i == SAOK) &&
                   (M_icode_i == IMRMOVQ || M_icode_i == IPOPQ || M_icode_i == IRET);
        is_wr    = (M_stat_i == SAOK) &&
                   (M_icode_i == IRMMOVQ || M_icode_i == IPUSHQ || M_icode_i == ICALL);
        is_mem   = is_rd || is_wr;
        addr_d   = (M_icode_i == IPOPQ || M_icode_i == IRET) ? M_valA_i : M_valE_i;
        in_range = ({1'b0, addr_d} + 65'd8) <= 65'(MEM_BYTES);
    end

    // Stall request and writeback-facing results.
    always_comb begin
        m_busy_o = rst_n_i && ((state_q == IDLE && is_mem && in_range) ||
                               state_q == REQ || state_q == WAIT);
        m_valM_o = (state_q == DONE) ? valm_q : 64'd0;
        m_stat_o = (state_q == DONE && err_q) ? SADR : M_stat_i;
    end

    assign mem_req_o     = req_q;
    assign mem_we_o      = we_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign m_stall_cnt_o = stall_q;

    // Access FSM with registered port outputs, results and stall counter.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            valm_q  <= 64'd0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            stall_q <= 32'd0;
        end else begin
            if (m_busy_o && stall_q != 32'hFFFF_FFFF)
                stall_q <= stall_q + 32'd1;
            case (state_q)
                IDLE: begin
                    if (is_mem && in_range) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        we_q    <= is_wr;
                        addr_q  <= addr_d;
                        wdata_q <= M_valA_i;
                        valm_q  <= 64'd0;
                    end else if (is_mem) begin
                        state_q <= DONE;
                        err_q   <= 1'b1;
                        valm_q  <= 64'd0;
                    end
                end
                REQ: begin
                    if (mem_ready_i) begin
                        req_q   <= 1'b0;
                        state_q <= we_q ? DONE : WAIT;
                        cnt_q   <= '0;
                    end
                end
                WAIT: begin
                    if (mem_rvalid_i) begin
                        state_q <= DONE;
                        err_q   <= mem_err_i;
                        valm_q  <= mem_err_i ? 64'd0 : mem_rdata_i;
                    end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                        state_q <= DONE;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (adv_i) begin
                        state_q <= IDLE;
                        err_q   <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule
